fpu_shared_unit_sched: RTL and testbench
========================================

# fpu_shared_unit_sched

Scheduler that shares one long-latency FPU resource (convert/divide unit feeding FUCVT) between the three FPU issue lanes u1, u3, u5. Each cycle it grants at most one requesting lane round-robin, issues the op to the shared unit with registered controls, and tracks in-flight ops in a latency-matched shift pipeline. It routes each completion back to its originating lane's ret/ret_en return port. Blocking (non-pipelined) ops are sequenced by a two-state FSM that holds off further grants until the result emerges.

## Interface
- LAT, 4, shared unit pipelined-op latency, iss_en to ret_en, in cycles (≥2)
- BLK_LAT, 12, blocking-op latency, iss_en to ret_en (must be > LAT)
- clk  input  1  clock; all state on posedge (negedge under `swapedge`)
- rst  input  1  synchronous, active-high reset
- u1_req, u3_req, u5_req  input  1 each  lane requests shared unit this cycle
- u1_blk, u3_blk, u5_blk  input  1 each  requested op is blocking; qualified by req
- u1_tag, u3_tag, u5_tag  input  14 each  return tag echoed on completion
- flush  input  1  kill all in-flight ops and pending blocking op
- u1_gnt, u3_gnt, u5_gnt  output  1 each  combinational one-hot grant, same cycle as req
- iss_en  output  1  registered issue strobe to shared unit
- iss_lane  output  2  registered lane of issued op: 0=u1, 1=u3, 2=u5
- iss_blk  output  1  registered blocking flag of issued op
- busy  output  1  FSM in BLOCK
- u1_ret, u3_ret, u5_ret  output  14 each  completion tag, zero when the lane's ret_en is low
- u1_ret_en, u3_ret_en, u5_ret_en  output  1 each  completion strobe

## Operation
- FSM states IDLE, BLOCK. Reset → IDLE.
- IDLE: grant the first requesting lane in round-robin order starting at rr_ptr. At most one gnt is high. rr_ptr ← granted lane+1 mod 3. rr_ptr unchanged when nothing is granted. Reset rr_ptr=0, giving priority u1>u3>u5.
- Grant with blk=1: next state BLOCK and blk_cnt ← BLK_LAT.
- BLOCK: all gnt=0 regardless of req. blk_cnt decrements every cycle from the cycle after iss_en. When blk_cnt reaches 1, the blocking completion fires and FSM → IDLE. Grants are legal again in that same completion cycle.
- Pipelined in-flight tracking: shift register of LAT entries {vld, lane[1:0], tag[13:0]}. Entry 0 is loaded from the issue register; the entry leaving stage LAT−1 drives return.
- Blocking in-flight tracking: single holding register {vld, lane, tag}, presented at completion.
- Return mux: a completion asserts exactly one lane's ret_en, selected by lane, and drives that lane's ret=tag. All other lanes show ret=0 and ret_en=0.
- Collision-free by construction: a pipelined op issued before a blocking op retires at most LAT−1 cycles after it, strictly before the blocking op (BLK_LAT>LAT). No pipelined op issues during BLOCK.
- flush: in the same cycle, gnt forced 0. Next edge: all shift vld bits cleared, blocking holder cleared, iss_en=0, FSM→IDLE, blk_cnt=0. rr_ptr is kept. No ret_en asserts after the flush edge for pre-flush ops.
- rst mid-operation: same as flush, and additionally rr_ptr=0.

## Timing
- Reset values: all gnt=0, iss_en=0, iss_lane=0, iss_blk=0, busy=0, all ret=0, all ret_en=0.
- Grant at cycle T → iss_en/iss_lane/iss_blk high at T+1.
- Pipelined op: ret_en at T+1+LAT.
- Blocking op: busy high T+1 … T+BLK_LAT. ret_en at T+1+BLK_LAT, with busy low in that cycle.
- Back-to-back pipelined grants: one per cycle. Sustained throughput 1 op/cycle.
- Requester must hold req until it sees gnt. A dropped req is not latched.
- req and flush in the same cycle: flush wins, no grant.

## Test plan
- Reset, then u1_req only, tag=0x0A5, LAT=4: u1_gnt at T0; iss_en, iss_lane=0 at T1; u1_ret_en with u1_ret=0x0A5 at T5, u3/u5 ret=0.
- All three req held 6 cycles, tags 0x11/0x33/0x55: grant order u1,u3,u5,u1,u3,u5; ret_en sequence over T5..T10 matches that order, one lane per cycle.
- u3_req blk=1 (tag 0x200) at T0 with u1/u5 requesting continuously, BLK_LAT=12: busy T1..T12, no gnt T1..T12; u3_ret_en/0x200 at T13; u5 granted at T13 (rr_ptr=2).
- Pipelined u1 grant at T0, blocking u5 grant at T1: u1_ret_en at T5, u5_ret_en at T14, never both in one cycle.
- Three pipelined ops issued, flush asserted at T3: no ret_en from T4 onward; new u5 req at T4 granted, and its ret arrives at T9.
- rst asserted during BLOCK at count 5: next cycle busy=0, all outputs at reset values; the next simultaneous req gives priority to u1.

Source files
------------

// File: rtl/fpu_shared_unit_sched.sv
// -----------------------------------------------------------------------------
// fpu_shared_unit_sched
//
// Shares one long-latency FPU resource (convert/divide unit) between the three
// FPU issue lanes u1, u3, u5. A round-robin arbiter grants at most one lane per
// cycle, the granted op is issued to the shared unit through registered
// controls, and in-flight ops are tracked so that each completion is routed
// back to the lane that issued it.
//
// Pipelined ops travel down a LAT-deep shift pipeline. Blocking ops park in a
// single holding register while a two-state FSM (IDLE/BLOCK) stops further
// grants until the blocking result comes out.
//
// Parameters
//   LAT      pipelined-op latency, iss_en to ret_en (>= 2)
//   BLK_LAT  blocking-op latency, iss_en to ret_en (> LAT)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   uN_req / uN_blk / uN_tag lane request, blocking flag, 14-bit return tag
//   flush                    kill everything in flight (rr pointer kept)
//   uN_gnt                   combinational one-hot grant
//   iss_en/iss_lane/iss_blk  registered issue strobe, lane (0=u1,1=u3,2=u5),
//                            blocking flag
//   busy                     FSM is in BLOCK
//   uN_ret / uN_ret_en       completion tag (zero when idle) and strobe
// -----------------------------------------------------------------------------
module fpu_shared_unit_sched #(
    parameter int LAT     = 4,
    parameter int BLK_LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        u1_req,
    input  logic        u3_req,
    input  logic        u5_req,
    input  logic        u1_blk,
    input  logic        u3_blk,
    input  logic        u5_blk,
    input  logic [13:0] u1_tag,
    input  logic [13:0] u3_tag,
    input  logic [13:0] u5_tag,
    input  logic        flush,
    output logic        u1_gnt,
    output logic        u3_gnt,
    output logic        u5_gnt,
    output logic        iss_en,
    output logic [1:0]  iss_lane,
    output logic        iss_blk,
    output logic        busy,
    output logic [13:0] u1_ret,
    output logic [13:0] u3_ret,
    output logic [13:0] u5_ret,
    output logic        u1_ret_en,
    output logic        u3_ret_en,
    output logic        u5_ret_en
);

    localparam int CW = $clog2(BLK_LAT + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Lane vectors (index 0=u1, 1=u3, 2=u5)
    // ------------------------------------------------------------------
    logic [2:0]  req_vec;
    logic [2:0]  blk_vec;
    logic [13:0] tag_vec [3];

    assign req_vec    = {u5_req, u3_req, u1_req};
    assign blk_vec    = {u5_blk, u3_blk, u1_blk};
    assign tag_vec[0] = u1_tag;
    assign tag_vec[1] = u3_tag;
    assign tag_vec[2] = u5_tag;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [CW-1:0]   blk_cnt_reg, blk_cnt_next;
    logic [1:0]      rr_ptr_reg, rr_ptr_next;

    logic            iss_en_reg;
    logic [1:0]      iss_lane_reg;
    logic            iss_blk_reg;
    logic [13:0]     iss_tag_reg;

    logic            pipe_vld_reg  [LAT];
    logic [1:0]      pipe_lane_reg [LAT];
    logic [13:0]     pipe_tag_reg  [LAT];

    logic            hold_vld_reg;
    logic [1:0]      hold_lane_reg;
    logic [13:0]     hold_tag_reg;

    // ------------------------------------------------------------------
    // Round-robin arbiter: search starts at rr_ptr and wraps mod 3.
    // ------------------------------------------------------------------
    logic [2:0] gnt_vec;
    logic       gnt_any;
    logic [1:0] gnt_lane;
    logic [2:0] rr_sum;
    logic [1:0] rr_idx;

    always_comb begin
        gnt_vec  = '0;
        gnt_any  = 1'b0;
        gnt_lane = 2'd0;
        rr_sum   = '0;
        rr_idx   = 2'd0;
        if (state_reg == IDLE && !flush && !rst) begin
            for (int k = 0; k < 3; k++) begin
                rr_sum = {1'b0, rr_ptr_reg} + 3'(k);
                if (rr_sum >= 3'd3) begin
                    rr_sum = rr_sum - 3'd3;
                end
                rr_idx = rr_sum[1:0];
                if (!gnt_any && req_vec[rr_idx]) begin
                    gnt_any  = 1'b1;
                    gnt_lane = rr_idx;
                end
            end
            gnt_vec[gnt_lane] = gnt_any;
        end
    end

    assign u1_gnt = gnt_vec[0];
    assign u3_gnt = gnt_vec[1];
    assign u5_gnt = gnt_vec[2];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_any) begin
            rr_ptr_next = (gnt_lane == 2'd2) ? 2'd0 : gnt_lane + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Blocking-op FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            blk_cnt_reg <= '0;
            rr_ptr_reg  <= 2'd0;
        end else begin
            state_reg   <= state_next;
            blk_cnt_reg <= blk_cnt_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        blk_cnt_next = blk_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_any && blk_vec[gnt_lane]) begin
                    state_next   = BLOCK;
                    blk_cnt_next = CW'(BLK_LAT);
                end
            end
            BLOCK: begin
                // Counter holds BLK_LAT in the issue cycle and leaves BLOCK
                // after the cycle in which it shows 1, so the result and the
                // return to IDLE land in the same cycle.
                if (blk_cnt_reg == CW'(1)) begin
                    state_next   = IDLE;
                    blk_cnt_next = '0;
                end else begin
                    blk_cnt_next = blk_cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                blk_cnt_next = '0;
            end
        endcase
        if (flush) begin
            state_next   = IDLE;
            blk_cnt_next = '0;
        end
    end

    assign busy = (state_reg == BLOCK);

    // ------------------------------------------------------------------
    // Issue register (grant is already suppressed under flush/rst)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_en_reg   <= 1'b0;
            iss_lane_reg <= 2'd0;
            iss_blk_reg  <= 1'b0;
            iss_tag_reg  <= '0;
        end else begin
            iss_en_reg   <= gnt_any;
            iss_lane_reg <= gnt_lane;
            iss_blk_reg  <= gnt_any & blk_vec[gnt_lane];
            iss_tag_reg  <= gnt_any ? tag_vec[gnt_lane] : 14'd0;
        end
    end

    assign iss_en   = iss_en_reg;
    assign iss_lane = iss_lane_reg;
    assign iss_blk  = iss_blk_reg;

    // ------------------------------------------------------------------
    // Pipelined in-flight tracker: stage 0 is fed from the issue register,
    // the last stage drives the return port.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    pipe_vld_reg[gi]  <= 1'b0;
                    pipe_lane_reg[gi] <= 2'd0;
                    pipe_tag_reg[gi]  <= '0;
                end else begin
                    if (gi == 0) begin
                        pipe_vld_reg[gi]  <= iss_en_reg & ~iss_blk_reg;
                        pipe_lane_reg[gi] <= iss_lane_reg;
                        pipe_tag_reg[gi]  <= iss_tag_reg;
                    end else begin
                        pipe_vld_reg[gi]  <= pipe_vld_reg[(gi > 0) ? gi - 1 : 0];
                        pipe_lane_reg[gi] <= pipe_lane_reg[(gi > 0) ? gi - 1 : 0];
                        pipe_tag_reg[gi]  <= pipe_tag_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Blocking holder. It is loaded while the FSM is in BLOCK, so a valid
    // holder seen in IDLE is exactly the completion cycle.
    // ------------------------------------------------------------------
    logic hold_fire;
    assign hold_fire = hold_vld_reg && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_vld_reg  <= 1'b0;
            hold_lane_reg <= 2'd0;
            hold_tag_reg  <= '0;
        end else if (iss_en_reg && iss_blk_reg) begin
            hold_vld_reg  <= 1'b1;
            hold_lane_reg <= iss_lane_reg;
            hold_tag_reg  <= iss_tag_reg;
        end else if (hold_fire) begin
            hold_vld_reg  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Return mux. Pipelined and blocking completions cannot coincide: any
    // pipelined op issued before a blocking op drains first, and nothing
    // issues while in BLOCK.
    // ------------------------------------------------------------------
    logic        ret_vld;
    logic [1:0]  ret_lane;
    logic [13:0] ret_tag;
    logic [2:0]  ret_en_vec;
    logic [13:0] ret_tag_vec [3];

    always_comb begin
        ret_vld  = 1'b0;
        ret_lane = 2'd0;
        ret_tag  = '0;
        if (pipe_vld_reg[LAT-1]) begin
            ret_vld  = 1'b1;
            ret_lane = pipe_lane_reg[LAT-1];
            ret_tag  = pipe_tag_reg[LAT-1];
        end else if (hold_fire) begin
            ret_vld  = 1'b1;
            ret_lane = hold_lane_reg;
            ret_tag  = hold_tag_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ret
            assign ret_en_vec[gi]  = ret_vld && (ret_lane == 2'(gi));
            assign ret_tag_vec[gi] = ret_en_vec[gi] ? ret_tag : 14'd0;
        end
    endgenerate

    assign u1_ret_en = ret_en_vec[0];
    assign u3_ret_en = ret_en_vec[1];
    assign u5_ret_en = ret_en_vec[2];
    assign u1_ret    = ret_tag_vec[0];
    assign u3_ret    = ret_tag_vec[1];
    assign u5_ret    = ret_tag_vec[2];

endmodule

// File: tb/tb_fpu_shared_unit_sched.sv
// -----------------------------------------------------------------------------
// Directed testbench for fpu_shared_unit_sched (LAT=4, BLK_LAT=12).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Cycle Tn below is the clock period in which the inputs of step n are applied.
// -----------------------------------------------------------------------------
module tb_fpu_shared_unit_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        u1_req = 1'b0, u3_req = 1'b0, u5_req = 1'b0;
    logic        u1_blk = 1'b0, u3_blk = 1'b0, u5_blk = 1'b0;
    logic [13:0] u1_tag = '0, u3_tag = '0, u5_tag = '0;
    logic        flush = 1'b0;
    logic        u1_gnt, u3_gnt, u5_gnt;
    logic        iss_en;
    logic [1:0]  iss_lane;
    logic        iss_blk;
    logic        busy;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;

    int n_cmp = 0;
    int n_err = 0;

    fpu_shared_unit_sched #(.LAT(4), .BLK_LAT(12)) dut (
        .clk(clk), .rst(rst),
        .u1_req(u1_req), .u3_req(u3_req), .u5_req(u5_req),
        .u1_blk(u1_blk), .u3_blk(u3_blk), .u5_blk(u5_blk),
        .u1_tag(u1_tag), .u3_tag(u3_tag), .u5_tag(u5_tag),
        .flush(flush),
        .u1_gnt(u1_gnt), .u3_gnt(u3_gnt), .u5_gnt(u5_gnt),
        .iss_en(iss_en), .iss_lane(iss_lane), .iss_blk(iss_blk), .busy(busy),
        .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
        .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
        $display("[%0t] %s obs=%0h exp=%0h", $time, name, obs, exp);
    endtask

    // {u5,u3,u1} grants
    function automatic logic [63:0] gnt_obs();
        return 64'({u5_gnt, u3_gnt, u1_gnt});
    endfunction

    // {iss_en, iss_lane, iss_blk, busy}
    function automatic logic [63:0] iss_obs();
        return 64'({iss_en, iss_lane, iss_blk, busy});
    endfunction

    function automatic logic [63:0] iss_exp(input logic en, input logic [1:0] lane,
                                            input logic blk, input logic bsy);
        return 64'({en, lane, blk, bsy});
    endfunction

    // {ret_en[u5,u3,u1], u5_ret, u3_ret, u1_ret}
    function automatic logic [63:0] ret_obs();
        return 64'({u5_ret_en, u3_ret_en, u1_ret_en, u5_ret, u3_ret, u1_ret});
    endfunction

    function automatic logic [63:0] ret_exp(input logic [2:0] en, input logic [13:0] tag);
        return 64'({en, en[2] ? tag : 14'd0, en[1] ? tag : 14'd0, en[0] ? tag : 14'd0});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drop_all();
        u1_req = 1'b0; u3_req = 1'b0; u5_req = 1'b0;
        u1_blk = 1'b0; u3_blk = 1'b0; u5_blk = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        rst = 1'b1;
        tick();
        smp();
        chk("rst_gnt", gnt_obs(), 64'd0);
        tick();
        rst = 1'b0;
        smp();
        chk("rst_iss", iss_obs(), 64'd0);
        chk("rst_ret", ret_obs(), 64'd0);
        tick();
    endtask

    logic [2:0]  exp_en;
    logic [13:0] exp_tag;

    initial begin
        // ---------------- power-on reset ----------------
        tick();
        do_reset();

        // ---------------- single pipelined u1 op ----------------
        $display("-- single u1 pipelined op");
        u1_req = 1'b1; u1_tag = 14'h0A5;                 // T0
        smp();
        chk("t1_gnt_T0", gnt_obs(), 64'b001);
        tick(); u1_req = 1'b0;                           // T1
        smp();
        chk("t1_iss_T1", iss_obs(), iss_exp(1'b1, 2'd0, 1'b0, 1'b0));
        chk("t1_gnt_T1", gnt_obs(), 64'd0);
        for (int t = 2; t <= 6; t++) begin
            tick(); smp();
            chk($sformatf("t1_ret_T%0d", t), ret_obs(),
                (t == 5) ? ret_exp(3'b001, 14'h0A5) : 64'd0);
        end
        tick();

        // ---------------- blocking u3 with u1/u5 contending (rr_ptr=1) ----------------
        $display("-- blocking u3 op, u1/u5 contending");
        u1_req = 1'b1; u1_tag = 14'h101;
        u3_req = 1'b1; u3_blk = 1'b1; u3_tag = 14'h200;
        u5_req = 1'b1; u5_tag = 14'h505;                 // T0
        smp();
        chk("t3_gnt_T0", gnt_obs(), 64'b010);
        tick(); u3_req = 1'b0; u3_blk = 1'b0;            // T1
        smp();
        chk("t3_iss_T1", iss_obs(), iss_exp(1'b1, 2'd1, 1'b1, 1'b1));
        for (int t = 1; t <= 12; t++) begin
            if (t > 1) begin tick(); smp(); end
            chk($sformatf("t3_gnt_T%0d", t), gnt_obs(), 64'd0);
            chk($sformatf("t3_busy_T%0d", t), 64'(busy), 64'd1);
            chk($sformatf("t3_ret_T%0d", t), ret_obs(), 64'd0);
        end
        tick(); smp();                                   // T13
        chk("t3_busy_T13", 64'(busy), 64'd0);
        chk("t3_ret_T13", ret_obs(), ret_exp(3'b010, 14'h200));
        chk("t3_gnt_T13", gnt_obs(), 64'b100);
        tick(); u5_req = 1'b0;                           // T14
        smp();
        chk("t3_gnt_T14", gnt_obs(), 64'b001);
        for (int t = 15; t <= 20; t++) begin
            tick();
            if (t == 15) u1_req = 1'b0;
            smp();
            exp_en  = (t == 18) ? 3'b100 : (t == 19) ? 3'b001 : 3'b000;
            exp_tag = (t == 18) ? 14'h505 : 14'h101;
            chk($sformatf("t3_ret_T%0d", t), ret_obs(), ret_exp(exp_en, exp_tag));
        end
        tick();

        // ---------------- pipelined u1 then blocking u5 ----------------
        $display("-- pipelined u1 then blocking u5");
        u1_req = 1'b1; u1_tag = 14'h0D1;                 // T0
        smp();
        chk("t4_gnt_T0", gnt_obs(), 64'b001);
        tick(); u1_req = 1'b0;
        u5_req = 1'b1; u5_blk = 1'b1; u5_tag = 14'h2D5;  // T1
        smp();
        chk("t4_gnt_T1", gnt_obs(), 64'b100);
        for (int t = 2; t <= 15; t++) begin
            tick();
            if (t == 2) begin u5_req = 1'b0; u5_blk = 1'b0; end
            smp();
            exp_en  = (t == 5) ? 3'b001 : (t == 14) ? 3'b100 : 3'b000;
            exp_tag = (t == 5) ? 14'h0D1 : 14'h2D5;
            chk($sformatf("t4_ret_T%0d", t), ret_obs(), ret_exp(exp_en, exp_tag));
            chk($sformatf("t4_busy_T%0d", t), 64'(busy), (t <= 13) ? 64'd1 : 64'd0);
        end
        tick();

        // ---------------- flush kills three in-flight ops ----------------
        $display("-- flush with three ops in flight");
        u1_req = 1'b1; u1_tag = 14'h0C1;                 // T0
        tick(); u1_req = 1'b0; u3_req = 1'b1; u3_tag = 14'h0C3;  // T1
        tick(); u3_req = 1'b0; u5_req = 1'b1; u5_tag = 14'h0C5;  // T2
        smp();
        chk("t5_gnt_T2", gnt_obs(), 64'b100);
        tick(); u5_req = 1'b0; flush = 1'b1; u1_req = 1'b1;      // T3
        smp();
        chk("t5_gnt_T3_flush", gnt_obs(), 64'd0);
        chk("t5_iss_T3", iss_obs(), iss_exp(1'b1, 2'd2, 1'b0, 1'b0));
        tick(); flush = 1'b0; u1_req = 1'b0;
        u5_req = 1'b1; u5_tag = 14'h3A5;                 // T4
        smp();
        chk("t5_gnt_T4", gnt_obs(), 64'b100);
        chk("t5_iss_T4", iss_obs(), 64'd0);
        chk("t5_ret_T4", ret_obs(), 64'd0);
        for (int t = 5; t <= 10; t++) begin
            tick();
            if (t == 5) u5_req = 1'b0;
            smp();
            if (t == 5) chk("t5_iss_T5", iss_obs(), iss_exp(1'b1, 2'd2, 1'b0, 1'b0));
            chk($sformatf("t5_ret_T%0d", t), ret_obs(),
                (t == 9) ? ret_exp(3'b100, 14'h3A5) : 64'd0);
        end
        tick();

        // ---------------- all three lanes, round robin ----------------
        $display("-- three lanes contending");
        do_reset();
        u1_tag = 14'h011; u3_tag = 14'h033; u5_tag = 14'h055;
        for (int t = 0; t <= 11; t++) begin
            if (t > 0) tick();
            if (t < 6) begin
                u1_req = 1'b1; u3_req = 1'b1; u5_req = 1'b1;
            end else begin
                drop_all();
            end
            smp();
            case (t % 3)
                0:       exp_en = 3'b001;
                1:       exp_en = 3'b010;
                default: exp_en = 3'b100;
            endcase
            chk($sformatf("t2_gnt_T%0d", t), gnt_obs(), (t < 6) ? 64'(exp_en) : 64'd0);
            case ((t + 1) % 3)
                0:       begin exp_en = 3'b001; exp_tag = 14'h011; end
                1:       begin exp_en = 3'b010; exp_tag = 14'h033; end
                default: begin exp_en = 3'b100; exp_tag = 14'h055; end
            endcase
            chk($sformatf("t2_ret_T%0d", t), ret_obs(),
                (t >= 5 && t <= 10) ? ret_exp(exp_en, exp_tag) : 64'd0);
        end
        tick();

        // ---------------- reset during BLOCK ----------------
        $display("-- reset while blocking op pending");
        u3_req = 1'b1; u3_blk = 1'b1; u3_tag = 14'h2E3;  // T0
        smp();
        chk("t6_gnt_T0", gnt_obs(), 64'b010);
        tick(); drop_all();                              // T1
        smp();
        chk("t6_busy_T1", 64'(busy), 64'd1);
        for (int t = 2; t <= 7; t++) tick();
        tick(); rst = 1'b1;                              // T8, blk_cnt=5
        smp();
        chk("t6_busy_T8", 64'(busy), 64'd1);
        tick(); rst = 1'b0;                              // T9
        smp();
        chk("t6_iss_T9", iss_obs(), 64'd0);
        chk("t6_gnt_T9", gnt_obs(), 64'd0);
        chk("t6_ret_T9", ret_obs(), 64'd0);
        for (int t = 10; t <= 14; t++) begin
            tick(); smp();
            chk($sformatf("t6_ret_T%0d", t), ret_obs(), 64'd0);
        end
        tick();
        u1_req = 1'b1; u3_req = 1'b1; u5_req = 1'b1;     // T15
        smp();
        chk("t6_gnt_T15", gnt_obs(), 64'b001);
        tick(); drop_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
